// File: rtl/piso_serializer.sv
// Parallel-in/serial-out front end: accepts a WIDTH-bit word over valid/ready
// and emits it one bit per clock with first/last/done frame markers.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             accept;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Ready during the last bit only when frames may run back-to-back.
  assign din_ready = !rst && ((state == IDLE) ||
                              (state == SHIFT && bit_cnt == CNT_LAST && GAP_CYCLES == 0));
  assign accept = din_valid && din_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_first <= 1'b0;
      sout_last  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      sout_first <= 1'b0;
      if (accept) begin
        // The head bit goes straight to sout; shreg keeps the remaining bits.
        state      <= SHIFT;
        bit_cnt    <= '0;
        sout       <= head_bit(din);
        shreg      <= advance(din);
        sout_valid <= 1'b1;
        sout_first <= 1'b1;
        sout_last  <= 1'b0;
        busy       <= 1'b1;
        frame_done <= (state == SHIFT);
      end else begin
        case (state)
          IDLE: ;
          SHIFT: begin
            if (bit_cnt == CNT_LAST) begin
              frame_done <= 1'b1;
              sout       <= 1'b0;
              sout_valid <= 1'b0;
              sout_last  <= 1'b0;
              if (GAP_CYCLES > 0) begin
                state   <= GAP;
                gap_cnt <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt   <= bit_cnt + CW'(1);
              sout      <= head_bit(shreg);
              shreg     <= advance(shreg);
              sout_last <= (bit_cnt == CNT_PENULT);
            end
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances cover MSB-first back-to-back,
// LSB-first, and a two-cycle inter-frame gap.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance A: MSB first, no gap
  logic [7:0] din_a = '0;
  logic       dv_a = 1'b0;
  logic       rdy_a, so_a, sv_a, sf_a, sl_a, bz_a, fd_a;
  // Instance B: LSB first, no gap
  logic [7:0] din_b = '0;
  logic       dv_b = 1'b0;
  logic       rdy_b, so_b, sv_b, sf_b, sl_b, bz_b, fd_b;
  // Instance C: MSB first, two-cycle gap
  logic [7:0] din_c = '0;
  logic       dv_c = 1'b0;
  logic       rdy_c, so_c, sv_c, sf_c, sl_c, bz_c, fd_c;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(dv_a), .din_ready(rdy_a),
    .sout(so_a), .sout_valid(sv_a), .sout_first(sf_a), .sout_last(sl_a),
    .busy(bz_a), .frame_done(fd_a));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(dv_b), .din_ready(rdy_b),
    .sout(so_b), .sout_valid(sv_b), .sout_first(sf_b), .sout_last(sl_b),
    .busy(bz_b), .frame_done(fd_b));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_c (
    .clk(clk), .rst(rst), .din(din_c), .din_valid(dv_c), .din_ready(rdy_c),
    .sout(so_c), .sout_valid(sv_c), .sout_first(sf_c), .sout_last(sl_c),
    .busy(bz_c), .frame_done(fd_c));

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one frame on instance A over eight cycles, starting in the first-bit cycle.
  task automatic frame_a(input string tag, input logic [7:0] bits);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_sout"}, so_a, bits[7-i]);
      check({tag, "_valid"}, sv_a, 1'b1);
      check({tag, "_first"}, sf_a, i == 0);
      check({tag, "_last"}, sl_a, i == 7);
      tick();
    end
  endtask

  initial begin
    logic [7:0] exp_bits;
    // 1: reset with a word offered
    #2;
    rst = 1'b1; dv_a = 1'b1; din_a = 8'hFF;
    tick();
    check("rst_ready", rdy_a, 1'b0);
    check("rst_valid", sv_a, 1'b0);
    check("rst_sout", so_a, 1'b0);
    check("rst_busy", bz_a, 1'b0);
    tick();
    check("rst_ready2", rdy_a, 1'b0);
    check("rst_done", fd_a, 1'b0);
    rst = 1'b0; dv_a = 1'b0;
    tick();
    check("post_rst_valid", sv_a, 1'b0);
    check("post_rst_ready", rdy_a, 1'b1);

    // 2: A5 MSB first
    din_a = 8'hA5; dv_a = 1'b1;
    check("t2_ready", rdy_a, 1'b1);
    tick();
    dv_a = 1'b0;
    check("t2_busy", bz_a, 1'b1);
    frame_a("t2", 8'b1010_0101);
    check("t2_done", fd_a, 1'b1);
    check("t2_busy_end", bz_a, 1'b0);
    check("t2_valid_end", sv_a, 1'b0);
    tick();
    check("t2_done_once", fd_a, 1'b0);

    // 3: 01 LSB first
    din_b = 8'h01; dv_b = 1'b1;
    tick();
    dv_b = 1'b0;
    exp_bits = 8'b1000_0000;
    for (int i = 0; i < 8; i++) begin
      check("t3_sout", so_b, exp_bits[7-i]);
      check("t3_valid", sv_b, 1'b1);
      check("t3_first", sf_b, i == 0);
      check("t3_last", sl_b, i == 7);
      tick();
    end
    check("t3_done", fd_b, 1'b1);
    check("t3_valid_end", sv_b, 1'b0);

    // 4: back-to-back A5 then 3C
    din_a = 8'hA5; dv_a = 1'b1;
    tick();
    din_a = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      check("t4_ready", rdy_a, i == 7);
      check("t4a_sout", so_a, exp_bits_a5(i));
      check("t4a_valid", sv_a, 1'b1);
      tick();
    end
    dv_a = 1'b0;
    check("t4_done1", fd_a, 1'b1);
    frame_a("t4b", 8'b0011_1100);
    check("t4_done2", fd_a, 1'b1);
    check("t4_valid_end", sv_a, 1'b0);

    // 5: two-cycle gap between frames
    din_c = 8'hA5; dv_c = 1'b1;
    tick();
    din_c = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      check("t5_sout", so_c, exp_bits_a5(i));
      check("t5_ready", rdy_c, 1'b0);
      tick();
    end
    check("t5_gap1_valid", sv_c, 1'b0);
    check("t5_gap1_ready", rdy_c, 1'b0);
    check("t5_gap1_busy", bz_c, 1'b1);
    check("t5_done", fd_c, 1'b1);
    tick();
    check("t5_gap2_valid", sv_c, 1'b0);
    check("t5_gap2_ready", rdy_c, 1'b0);
    tick();
    check("t5_idle_ready", rdy_c, 1'b1);
    check("t5_idle_valid", sv_c, 1'b0);
    tick();
    dv_c = 1'b0;
    check("t5_f2_valid", sv_c, 1'b1);
    check("t5_f2_first", sf_c, 1'b1);
    check("t5_f2_sout", so_c, 1'b0);
    repeat (10) tick();

    // 6: reset after three bits, then a clean 0F frame
    din_a = 8'hA5; dv_a = 1'b1;
    tick();
    dv_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t6_sout", so_a, exp_bits_a5(i));
      if (i < 2) tick();
    end
    rst = 1'b1;
    tick();
    check("t6_rst_valid", sv_a, 1'b0);
    check("t6_rst_sout", so_a, 1'b0);
    check("t6_rst_busy", bz_a, 1'b0);
    check("t6_rst_done", fd_a, 1'b0);
    check("t6_rst_ready", rdy_a, 1'b0);
    rst = 1'b0;
    tick();
    check("t6_post_done", fd_a, 1'b0);
    check("t6_post_valid", sv_a, 1'b0);
    check("t6_post_ready", rdy_a, 1'b1);
    din_a = 8'h0F; dv_a = 1'b1;
    tick();
    dv_a = 1'b0;
    frame_a("t6", 8'b0000_1111);
    check("t6_done", fd_a, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic exp_bits_a5(input int i);
    logic [7:0] w;
    w = 8'b1010_0101;
    return w[7-i];
  endfunction

endmodule
